uart_tx_buffer: RTL

- Transmit-side staging buffer in front of uart_core.
- Accepts bytes from the host side through a valid/ready write port and stores them in a FIFO.
- Launches them one at a time into uart_core by pulsing tx_start with tx_data held stable, then tracks tx_busy until the frame completes.
- Lets the host queue bursts without polling tx_busy.

---
 rtl/uart_tx_buffer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: transmit staging FIFO in front of uart_core.
// Host bytes are queued through a valid/ready write port and launched one at
// a time into uart_core with a single-cycle tx_start pulse. tx_busy is then
// tracked until the frame completes, so the host can queue bursts without
// polling the core.
//
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   wr_data      byte to enqueue
//   wr_valid     write request; a write happens on wr_valid & wr_ready
//   wr_ready     registered "FIFO not full"
//   flush        discard queued bytes, clear overflow and launch_err
//   tx_busy      registered busy flag from uart_core
//   tx_start     one-cycle launch pulse to uart_core
//   tx_data      byte presented to uart_core, held until the next launch
//   fifo_count   queued entries, 0..DEPTH
//   empty        fifo_count == 0
//   overflow     sticky: write attempted while full
//   launch_err   sticky: tx_busy never rose within BUSY_TIMEOUT after a launch
module uart_tx_buffer #(
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned AW           = 3,
    parameter int unsigned BUSY_TIMEOUT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    wr_data,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic          flush,
    input  logic          tx_busy,
    output logic          tx_start,
    output logic [7:0]    tx_data,
    output logic [AW:0]   fifo_count,
    output logic          empty,
    output logic          overflow,
    output logic          launch_err
);

    localparam int unsigned TW = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [TW-1:0] timer;
    state_t        state;

    logic          push;
    logic          pop;
    logic [AW:0]   count_next;

    // Push/pop qualification; flush drops a same-cycle write and holds off a launch.
    always_comb begin
        push       = wr_valid & wr_ready & ~flush;
        pop        = (state == IDLE) & ~empty & ~flush;
        count_next = fifo_count + (AW+1)'(push) - (AW+1)'(pop);
        if (flush) begin
            count_next = '0;
        end
    end

    // Storage array; contents need no reset since pointers gate every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy and the registered full/empty views of it.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
            empty      <= 1'b1;
            wr_ready   <= 1'b1;
            overflow   <= 1'b0;
        end else begin
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                // AW-bit pointers wrap modulo DEPTH on their own.
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
            end
            fifo_count <= count_next;
            empty      <= (count_next == '0);
            wr_ready   <= (count_next != (AW+1)'(DEPTH));
            if (flush) begin
                overflow <= 1'b0;
            end else if (wr_valid && !wr_ready) begin
                overflow <= 1'b1;
            end
        end
    end

    // Launch sequencer: pulse tx_start, then follow tx_busy through the frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            tx_start   <= 1'b0;
            tx_data    <= 8'h00;
            timer      <= '0;
            launch_err <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        tx_data  <= mem[rd_ptr];
                        tx_start <= 1'b1;
                        state    <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    timer <= '0;
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    // tx_busy lags the core by a cycle, so a few low samples are normal.
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (timer == TW'(BUSY_TIMEOUT - 1)) begin
                        timer      <= timer + 1'b1;
                        launch_err <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
            // Flush clears the error flag but leaves an in-flight frame tracked.
            if (flush) begin
                launch_err <= 1'b0;
            end
        end
    end

endmodule
